// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over the icache port and holds instr for decode.
// Define IFU_PERF_EN to build the fetch/stall performance counters (otherwise tied to zero).
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        advance,
  input  logic [1:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] pc;
  logic [W-1:0] next_pc;
  logic [W-1:0] br_off;

  assign pc_plus4 = pc + W'(4);
  assign iaddr    = {pc[W-1:2], 2'b00};

  // Next-PC select from the control unit's decode results; all arithmetic is modulo 2^32.
  always_comb begin
    br_off  = {{14{imm[15]}}, imm, 2'b00};
    next_pc = pc_plus4;
    case (pcsrc)
      2'd1:    if (branch_taken) next_pc = pc_plus4 + br_off;
      2'd2:    next_pc = {pc_plus4[W-1:28], jaddr, 2'b00};
      2'd3:    next_pc = rs_data & ~W'(3);
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      iREN        <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            instr       <= iload;
            instr_valid <= 1'b1;
            iREN        <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          // halt wins over a simultaneous advance
          if (halt) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            iREN        <= 1'b0;
            state       <= HALTED;
          end else if (advance) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            iREN        <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          instr_valid <= 1'b0;
          halted      <= 1'b1;
          iREN        <= 1'b0;
          state       <= HALTED;
        end
      endcase
    end
  end

`ifdef IFU_PERF_EN
  // Counters only move in FETCH, so they freeze in EXEC and HALTED.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (state == FETCH) begin
      if (ihit) fetch_cnt <= fetch_cnt + W'(1);
      else      stall_cnt <= stall_cnt + W'(1);
    end
  end
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: next-PC vector table plus reset/halt/stall sequences.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] iload = '0;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        advance = 1'b0;
  logic [1:0]  pcsrc = '0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm = '0;
  logic [25:0] jaddr = '0;
  logic [31:0] rs_data = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .instr(instr), .instr_valid(instr_valid), .advance(advance), .pcsrc(pcsrc),
    .branch_taken(branch_taken), .imm(imm), .jaddr(jaddr), .rs_data(rs_data),
    .halt(halt), .halted(halted), .pc_plus4(pc_plus4), .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] setpc;
    logic [1:0]  pcsrc;
    logic        taken;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] rs;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_stall = '0;
  logic [31:0] last_instr = '0;
  logic [31:0] cur_pc = '0;

  function automatic logic [31:0] ef();
`ifdef IFU_PERF_EN
    return m_fetch;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] es();
`ifdef IFU_PERF_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Asserted mid-cycle so the checks prove the reset is asynchronous.
  task automatic do_reset();
    nRST = 1'b0;
    #1;
    m_fetch = '0;
    m_stall = '0;
    last_instr = '0;
    exp_q.delete();
    exp_q.push_back(32'h0000_0000);
    chk("rst_iren", 32'(iREN), 32'd1);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // DUT is in FETCH: check the address against the scoreboard, stall, then deliver a word.
  task automatic do_fetch(input logic [31:0] w, input int stalls);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty actual=empty expected=pending_iaddr t=%0t", $time);
    end else begin
      cur_pc = exp_q.pop_front();
      chk("iaddr", iaddr, cur_pc);
    end
    chk("fetch_iren", 32'(iREN), 32'd1);
    chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
    for (int s = 0; s < stalls; s++) begin
      ihit = 1'b0;
      iload = 32'hDEAD_0000 | 32'(s);
      @(posedge CLK);
      #1;
      m_stall++;
      chk("stall_iren", 32'(iREN), 32'd1);
      chk("stall_instr", instr, last_instr);
      chk("stall_valid", 32'(instr_valid), 32'd0);
      chk("stall_iaddr", iaddr, cur_pc);
    end
    ihit = 1'b1;
    iload = w;
    @(posedge CLK);
    #1;
    ihit = 1'b0;
    m_fetch++;
    last_instr = w;
    chk("instr", instr, w);
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("exec_iren", 32'(iREN), 32'd0);
    chk("fetch_cnt", fetch_cnt, ef());
    chk("stall_cnt", stall_cnt, es());
  endtask

  // DUT is in EXEC: retire the instruction and queue the expected next fetch address.
  task automatic do_adv(input logic [1:0] ps, input logic tk, input logic [15:0] im,
                        input logic [25:0] ja, input logic [31:0] rs, input logic [31:0] exp);
    pcsrc = ps;
    branch_taken = tk;
    imm = im;
    jaddr = ja;
    rs_data = rs;
    advance = 1'b1;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    advance = 1'b0;
    chk("adv_valid", 32'(instr_valid), 32'd0);
    chk("adv_iren", 32'(iREN), 32'd1);
    chk("adv_instr_held", instr, last_instr);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0010, 2'd1, 1'b1, 16'hFFFC, 26'h0,       32'h0,         32'h0000_0004};
    vecs[1]  = '{32'h0000_0010, 2'd1, 1'b0, 16'hFFFC, 26'h0,       32'h0,         32'h0000_0014};
    vecs[2]  = '{32'h8000_0020, 2'd2, 1'b0, 16'h0,    26'h10,      32'h0,         32'h8000_0040};
    vecs[3]  = '{32'h8000_0020, 2'd3, 1'b0, 16'h0,    26'h0,       32'h0000_0103, 32'h0000_0100};
    vecs[4]  = '{32'hFFFF_FFFC, 2'd0, 1'b0, 16'h0,    26'h0,       32'h0,         32'h0000_0000};
    vecs[5]  = '{32'h0000_0100, 2'd1, 1'b1, 16'h0010, 26'h0,       32'h0,         32'h0000_0144};
    vecs[6]  = '{32'hFFFF_FFF8, 2'd1, 1'b1, 16'h0001, 26'h0,       32'h0,         32'h0000_0000};
    vecs[7]  = '{32'hF000_0000, 2'd2, 1'b0, 16'h0,    26'h3FF_FFFF, 32'h0,        32'hFFFF_FFFC};
    vecs[8]  = '{32'h0FFF_FFFC, 2'd2, 1'b0, 16'h0,    26'h1,       32'h0,         32'h1000_0004};
    vecs[9]  = '{32'h0000_0200, 2'd3, 1'b0, 16'h0,    26'h0,       32'hDEAD_BEEF, 32'hDEAD_BEEC};
    vecs[10] = '{32'h0000_0020, 2'd1, 1'b1, 16'h8000, 26'h0,       32'h0,         32'hFFFE_0024};

    do_reset();

    // First word on the first cycle out of reset, then sequential advance with a 3-cycle stall.
    do_fetch(32'h2401_0005, 0);
    iload = 32'h1111_2222;
    ihit = 1'b1;
    @(posedge CLK);
    #1;
    ihit = 1'b0;
    chk("exec_ihit_ignored_instr", instr, 32'h2401_0005);
    chk("exec_ihit_ignored_valid", 32'(instr_valid), 32'd1);
    chk("exec_ihit_ignored_cnt", fetch_cnt, ef());
    do_adv(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_0004);
    pcsrc = 2'd3;
    rs_data = 32'h0000_0500;
    advance = 1'b1;
    @(posedge CLK);
    #1;
    advance = 1'b0;
    m_stall++;
    chk("fetch_adv_ignored", iaddr, 32'h0000_0004);
    do_fetch(32'h3C01_1234, 3);

    for (int i = 0; i < 11; i++) begin
      do_adv(2'd3, 1'b0, 16'h0, 26'h0, vecs[i].setpc, vecs[i].setpc);
      do_fetch(32'hA000_0000 | 32'(i), i % 3);
      do_adv(vecs[i].pcsrc, vecs[i].taken, vecs[i].imm, vecs[i].jaddr, vecs[i].rs, vecs[i].exp);
      do_fetch(32'hB000_0000 | 32'(i), 0);
    end

    // halt together with advance: halt wins, PC and counters freeze, ihit ignored.
    halt = 1'b1;
    advance = 1'b1;
    pcsrc = 2'd0;
    @(posedge CLK);
    #1;
    halt = 1'b0;
    advance = 1'b0;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_iren", 32'(iREN), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_iaddr", iaddr, cur_pc);
    for (int k = 0; k < 3; k++) begin
      ihit = 1'b1;
      advance = 1'b1;
      iload = 32'h5555_0000 | 32'(k);
      @(posedge CLK);
      #1;
      chk("halted_iaddr", iaddr, cur_pc);
      chk("halted_iren", 32'(iREN), 32'd0);
      chk("halted_flag", 32'(halted), 32'd1);
      chk("halted_instr", instr, last_instr);
      chk("halted_fetch_cnt", fetch_cnt, ef());
      chk("halted_stall_cnt", stall_cnt, es());
    end
    ihit = 1'b0;
    advance = 1'b0;

    // Reset leaves HALTED; then reset again in the middle of a stalled fetch at 0x40.
    do_reset();
    do_fetch(32'h0000_0001, 0);
    do_adv(2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_0040, 32'h0000_0040);
    chk("pre_rst_iaddr", iaddr, 32'h0000_0040);
    @(posedge CLK);
    #2;
    do_reset();
    do_fetch(32'h0000_0002, 1);
    do_adv(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_0004);
    do_fetch(32'h0000_0003, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
